// File: rtl/gate_net_evaluator.sv
// gate_net_evaluator: sweeps a 2-input gate table until the netlist settles or is declared oscillating
module gate_net_evaluator #(
    parameter int N_IN = 32,
    parameter int N_GATES = 64,
    parameter int MAX_SWEEPS = 16,
    localparam int IDX_W = $clog2(N_IN + N_GATES),
    localparam int GA_W = $clog2(N_GATES),
    localparam int SW_W = $clog2(MAX_SWEEPS + 1),
    localparam int NN = N_IN + N_GATES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [GA_W-1:0]  cfg_addr,
    input  logic [1:0]       cfg_op,
    input  logic [IDX_W-1:0] cfg_src_a,
    input  logic [IDX_W-1:0] cfg_src_b,
    input  logic [N_IN-1:0]  in_vec,
    input  logic [IDX_W-1:0] out_sel,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             settled,
    output logic             oscillating,
    output logic             result,
    output logic [SW_W-1:0]  sweeps
);
    typedef enum logic [1:0] {IDLE, EVAL, FIN} state_t;
    state_t state;
    logic [1:0] op_t [N_GATES];
    logic [IDX_W-1:0] sa_t [N_GATES];
    logic [IDX_W-1:0] sb_t [N_GATES];
    logic [N_GATES-1:0] gs, gs_nxt;
    logic [N_IN-1:0] in_lat;
    logic [IDX_W-1:0] out_lat;
    logic [GA_W-1:0] ptr;
    logic chg, chg_any, last, a, b, val;
    logic [2**IDX_W-1:0] nodes, nodes_nxt;
    // node lookup with zero padding for out-of-range indices, gate evaluation and post-write view
    always_comb begin
        nodes = '0;
        nodes[NN-1:0] = {gs, in_lat};
        a = nodes[sa_t[ptr]];
        b = nodes[sb_t[ptr]];
        val = cfg_op_eval(op_t[ptr], a, b);
        gs_nxt = gs;
        gs_nxt[ptr] = val;
        nodes_nxt = '0;
        nodes_nxt[NN-1:0] = {gs_nxt, in_lat};
        chg_any = chg | (val != gs[ptr]);
        last = ptr == GA_W'(N_GATES - 1);
    end
    function automatic logic cfg_op_eval(input logic [1:0] op, input logic x, input logic y);
        return op == 2'd0 ? (x | y) : op == 2'd1 ? (x & y) : op == 2'd2 ? ~x : ~(x & y);
    endfunction
    // table writes, sweep FSM and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            settled <= 1'b0;
            oscillating <= 1'b0;
            result <= 1'b0;
            sweeps <= '0;
            gs <= '0;
            ptr <= '0;
            chg <= 1'b0;
            in_lat <= '0;
            out_lat <= '0;
            for (int i = 0; i < N_GATES; i++) begin
                op_t[i] <= 2'd1;
                sa_t[i] <= '0;
                sb_t[i] <= '0;
            end
        end else begin
            if (cfg_we && !busy) begin
                op_t[cfg_addr] <= cfg_op;
                sa_t[cfg_addr] <= cfg_src_a;
                sb_t[cfg_addr] <= cfg_src_b;
            end
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    in_lat <= in_vec;
                    out_lat <= out_sel;
                    gs <= '0;
                    ptr <= '0;
                    sweeps <= '0;
                    chg <= 1'b0;
                    settled <= 1'b0;
                    oscillating <= 1'b0;
                    busy <= 1'b1;
                    state <= EVAL;
                end
                EVAL: begin
                    gs <= gs_nxt;
                    ptr <= last ? '0 : ptr + GA_W'(1);
                    chg <= chg_any;
                    if (last) begin
                        sweeps <= sweeps + SW_W'(1);
                        if (!chg_any || sweeps + SW_W'(1) == SW_W'(MAX_SWEEPS)) begin
                            settled <= !chg_any;
                            oscillating <= chg_any;
                            result <= nodes_nxt[out_lat];
                            done <= 1'b1;
                            state <= FIN;
                        end else begin
                            chg <= 1'b0;
                        end
                    end
                end
                default: begin
                    busy <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gate_net_evaluator.sv
// tb_gate_net_evaluator: directed and randomized checks against a sweep-level netlist model
module tb_gate_net_evaluator;
    localparam int N_IN = 32;
    localparam int N_GATES = 64;
    localparam int MAX_SWEEPS = 16;
    logic clk = 0;
    logic rst = 1;
    logic cfg_we = 0;
    logic [5:0] cfg_addr = 0;
    logic [1:0] cfg_op = 0;
    logic [6:0] cfg_src_a = 0;
    logic [6:0] cfg_src_b = 0;
    logic [31:0] in_vec = 0;
    logic [6:0] out_sel = 0;
    logic start = 0;
    logic busy, done, settled, oscillating, result;
    logic [4:0] sweeps;
    int n_chk = 0;
    int n_err = 0;
    int m_op [N_GATES];
    int m_sa [N_GATES];
    int m_sb [N_GATES];
    int last_cyc;

    gate_net_evaluator #(.N_IN(N_IN), .N_GATES(N_GATES), .MAX_SWEEPS(MAX_SWEEPS)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_op(cfg_op),
        .cfg_src_a(cfg_src_a), .cfg_src_b(cfg_src_b), .in_vec(in_vec), .out_sel(out_sel),
        .start(start), .busy(busy), .done(done), .settled(settled),
        .oscillating(oscillating), .result(result), .sweeps(sweeps)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int g = 0; g < N_GATES; g++) begin
            m_op[g] = 1;
            m_sa[g] = 0;
            m_sb[g] = 0;
        end
    endtask

    function automatic void ref_eval(input logic [31:0] iv, input int sel, output int s,
                                     output int st, output int osc, output int res);
        bit nv [128];
        bit ch, x, y, v;
        foreach (nv[i]) nv[i] = 0;
        for (int i = 0; i < N_IN; i++) nv[i] = iv[i];
        st = 0;
        s = 0;
        for (int sw = 1; sw <= MAX_SWEEPS; sw++) begin
            ch = 0;
            s = sw;
            for (int g = 0; g < N_GATES; g++) begin
                x = nv[m_sa[g]];
                y = nv[m_sb[g]];
                case (m_op[g])
                    0: v = x | y;
                    1: v = x & y;
                    2: v = !x;
                    default: v = !(x & y);
                endcase
                if (v != nv[N_IN + g]) ch = 1;
                nv[N_IN + g] = v;
            end
            if (!ch) begin
                st = 1;
                break;
            end
        end
        osc = !st;
        res = nv[sel];
    endfunction

    task automatic cfg(input int g, input int op, input int sa, input int sb);
        @(negedge clk);
        cfg_we = 1;
        cfg_addr = 6'(g);
        cfg_op = 2'(op);
        cfg_src_a = 7'(sa);
        cfg_src_b = 7'(sb);
        @(posedge clk);
        #1 cfg_we = 0;
        m_op[g] = op;
        m_sa[g] = sa;
        m_sb[g] = sb;
    endtask

    task automatic run(input logic [31:0] iv, input int sel, input int dist_at, input int rst_at);
        int cyc, s, st, osc, res;
        ref_eval(iv, sel, s, st, osc, res);
        @(negedge clk);
        in_vec = iv;
        out_sel = 7'(sel);
        start = 1;
        @(posedge clk);
        #1 start = 0;
        check("busy_set", busy, 1);
        cyc = 0;
        while (!done && cyc < 1200) begin
            @(posedge clk);
            #1 cyc++;
            start = 0;
            cfg_we = 0;
            if (cyc == dist_at) begin
                start = 1;
                cfg_we = 1;
                cfg_addr = 0;
                cfg_op = 0;
                cfg_src_a = 0;
                cfg_src_b = 0;
            end
            if (cyc == rst_at) begin
                rst = 1;
                @(posedge clk);
                #1 rst = 0;
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_settled", settled, 0);
                check("rst_osc", oscillating, 0);
                check("rst_result", result, 0);
                check("rst_sweeps", sweeps, 0);
                last_cyc = cyc;
                return;
            end
        end
        last_cyc = cyc;
        check("done_seen", done, 1);
        check("done_cycle", cyc, s * N_GATES);
        check("settled", settled, st);
        check("oscillating", oscillating, osc);
        check("result", result, res);
        check("sweeps", sweeps, s);
        @(posedge clk);
        #1 check("busy_clear", busy, 0);
        check("done_pulse", done, 0);
    endtask

    initial begin
        logic [31:0] iv;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_settled", settled, 0);
        check("reset_osc", oscillating, 0);
        check("reset_result", result, 0);
        check("reset_sweeps", sweeps, 0);
        @(negedge clk) rst = 0;

        iv = $urandom | 32'h1;
        run(iv, 32, -1, -1);
        check("dflt_settled", settled, 1);
        check("dflt_sweeps", sweeps, 2);
        check("dflt_result", result, 1);
        check("dflt_cycle", last_cyc, 128);

        cfg(0, 0, 0, 127);
        iv = $urandom & ~32'h1;
        run(iv, 32, -1, -1);
        check("oor_result", result, 0);
        check("oor_settled", settled, 1);
        check("oor_sweeps", sweeps, 1);

        cfg(0, 3, 0, 33);
        cfg(1, 3, 1, 32);
        iv = ($urandom & ~32'h3) | 32'h2;
        run(iv, 33, -1, -1);
        check("latch_settled", settled, 1);
        check("latch_sweeps", sweeps, 2);
        check("latch_q33", result, 0);
        run(iv, 32, -1, -1);
        check("latch_q32", result, 1);

        cfg(0, 2, 32, 0);
        cfg(1, 1, 0, 0);
        iv = $urandom & ~32'h1;
        run(iv, 32, -1, -1);
        check("ring_osc", oscillating, 1);
        check("ring_settled", settled, 0);
        check("ring_sweeps", sweeps, 16);
        check("ring_cycle", last_cyc, 1024);

        run(iv, 32, 300, -1);
        check("dist_osc", oscillating, 1);
        check("dist_cycle", last_cyc, 1024);
        run(iv, 32, -1, -1);
        check("dist_table_kept", oscillating, 1);

        run(iv, 32, -1, 140);
        model_reset();
        iv = $urandom | 32'h1;
        run(iv, 32, -1, -1);
        check("post_rst_settled", settled, 1);
        check("post_rst_sweeps", sweeps, 2);

        for (int k = 0; k < 10; k++) begin
            for (int g = 0; g < N_GATES; g++) begin
                int hi;
                hi = ($urandom_range(0, 3) == 0) ? 127 : N_IN + g - 1;
                cfg(g, $urandom_range(0, 3), $urandom_range(0, hi), $urandom_range(0, hi));
            end
            for (int r = 0; r < 2; r++) run($urandom, $urandom_range(0, 127), -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
